// File: rtl/convout_streamer_pkg.sv
// convout_streamer_pkg: shared widths and state encoding for the convolution read-back streamer.
package convout_streamer_pkg;
   localparam int BYTE_W     = 8;
   localparam int WORD_W_DEF = 32;
   localparam int ADDR_W_DEF = 16;
   typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, FINISH} cs_state_t;
   function automatic int idx_w(input int word_w);
      return (word_w / BYTE_W > 1) ? $clog2(word_w / BYTE_W) : 1;
   endfunction
endpackage

// File: rtl/convout_streamer_word_serializer.sv
// word_serializer: shifts one RAM word out MSB byte first and holds the prefetched next word.
module word_serializer
   import convout_streamer_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF
)(
   input  logic              clk_spi,
   input  logic              reset,
   input  logic              active,
   input  logic              load,
   input  logic              pf_req,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic              sink_ready,
   output logic              sink_valid,
   output logic [7:0]        sink_data,
   output logic              first,
   output logic              last,
   output logic              next_avail
);
   localparam int NB = WORD_W / BYTE_W;
   localparam int IW = idx_w(WORD_W);
   logic [WORD_W-1:0] shreg, pf_reg;
   logic [IW-1:0]     idx;
   logic              pf_valid, pf_pend, xfer, reload;
   assign sink_valid = active;
   assign sink_data  = shreg[WORD_W-1 -: BYTE_W];
   assign xfer       = active && sink_ready;
   assign last       = xfer && idx == IW'(NB - 1);
   // a prefetch still on the RAM bus counts as available: reload straight from mem_rdata
   assign next_avail = pf_valid || pf_pend;
   assign reload     = last && next_avail;
   always_ff @(posedge clk_spi) begin
      if (reset) begin
         shreg    <= '0;
         pf_reg   <= '0;
         idx      <= '0;
         first    <= 1'b0;
         pf_valid <= 1'b0;
         pf_pend  <= 1'b0;
      end else begin
         pf_pend <= pf_req;
         if (load || reload) begin
            shreg <= (reload && pf_valid) ? pf_reg : mem_rdata;
            idx   <= '0;
            first <= 1'b1;
         end else begin
            if (xfer) begin
               shreg <= shreg << BYTE_W;
               idx   <= idx + IW'(1);
            end
            if (active) first <= 1'b0;
         end
         if (reload) pf_valid <= 1'b0;
         else if (pf_pend && !load) begin
            pf_reg   <= mem_rdata;
            pf_valid <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/convout_streamer.sv
// convout_streamer: reads a word range from the conv output RAM and streams it bytewise to the SPI sink.
module convout_streamer
   import convout_streamer_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
)(
   input  logic              clk_spi,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] word_count,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              sink_valid,
   output logic [7:0]        sink_data,
   input  logic              sink_ready,
   output logic              busy,
   output logic              done
);
   cs_state_t         state, state_n;
   logic [ADDR_W-1:0] remain;
   logic              zero_wait, pf_req, first, last, next_avail, more, accept;
   assign accept    = state == IDLE && start;
   assign more      = remain != '0;
   assign pf_req    = state == SEND && first && more;
   assign mem_rd_en = state == FETCH || pf_req;
   assign busy      = state != IDLE;
   always_comb begin
      state_n = state;
      done    = 1'b0;
      case (state)
         IDLE:   if (start) state_n = (word_count == '0) ? FINISH : FETCH;
         FETCH:  state_n = LOAD;
         LOAD:   state_n = SEND;
         // a prefetch issued on the last byte itself is picked up via LOAD
         SEND:   if (last) state_n = next_avail ? SEND : pf_req ? LOAD : more ? FETCH : FINISH;
         FINISH: begin
            done    = !zero_wait;
            state_n = zero_wait ? FINISH : IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   // zero_wait stretches an empty command so done lands two cycles after start
   always_ff @(posedge clk_spi) begin
      if (reset) begin
         state     <= IDLE;
         mem_addr  <= '0;
         remain    <= '0;
         zero_wait <= 1'b0;
      end else begin
         state     <= state_n;
         zero_wait <= accept ? word_count == '0 : zero_wait && state != FINISH;
         if (accept) begin
            mem_addr <= base_addr;
            remain   <= word_count;
         end else if (mem_rd_en) begin
            mem_addr <= mem_addr + 1'b1;
            remain   <= remain - 1'b1;
         end
      end
   end
   word_serializer #(.WORD_W(WORD_W)) u_ser (
      .clk_spi    (clk_spi),
      .reset      (reset),
      .active     (state == SEND),
      .load       (state == LOAD),
      .pf_req     (pf_req),
      .mem_rdata  (mem_rdata),
      .sink_ready (sink_ready),
      .sink_valid (sink_valid),
      .sink_data  (sink_data),
      .first      (first),
      .last       (last),
      .next_avail (next_avail)
   );
endmodule
